// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target (responder).
//
// The SPI pins are oversampled in the clk domain. MOSI is deserialised into bytes that leave
// through a valid/ready handshake. Bytes from a one-entry transmit holding register are
// serialised onto MISO. The system clock must be at least 4x SCK.
//
// Build option: define SPI_TARGET_LSB_FIRST_EN to send and receive LSB first in both
// directions. When it is not defined, both directions are MSB first.
//
// Ports:
//   clk, rst            system clock; synchronous active-high reset
//   spi_cs              chip select from master, active low
//   spi_sck             serial clock, idles low
//   spi_mosi            master-out data
//   spi_miso            target-out data, registered
//   tx_data/valid/ready byte to transmit; transfer on tx_valid && tx_ready
//   rx_data/valid/ready received byte; held until rx_ready
//   overrun             one-cycle pulse when a received byte is dropped
//   busy                high while a transfer is in progress (FSM not idle)
module spi_target #(
   parameter logic [7:0]  FILL_BYTE   = 8'hFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_cs,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   state_e                 state;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   cs_s;
   logic                   sck_s;
   logic                   mosi_s;
   logic                   sck_d;
   logic                   sck_rise;
   logic                   sck_fall;

   logic [7:0]             hold;
   logic                   hold_full;
   // The byte now in tx_shift came from the holding register. The holding register is
   // still considered full until the first SCK rise of that byte.
   logic                   hold_loaded;
   logic [7:0]             tx_shift;
   // Only the 7 bits already received are kept. The 8th bit goes straight into rx_data.
   logic [6:0]             rx_shift;
   logic [2:0]             bit_cnt;

   logic [7:0]             load_byte;
   logic                   load_bit;
   logic [7:0]             tx_next;
   logic                   tx_next_bit;
   logic [7:0]             rx_next;
   logic [6:0]             rx_keep;

   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign tx_ready = ~hold_full;

   // Bit-order dependent datapath. The tx register rotates instead of shifting. This behaves
   // the same on the wire, because the register is reloaded at every byte boundary.
   always_comb begin
      load_byte = hold_full ? hold : FILL_BYTE;
`ifdef SPI_TARGET_LSB_FIRST_EN
      load_bit    = load_byte[0];
      tx_next     = {tx_shift[0], tx_shift[7:1]};
      tx_next_bit = tx_next[0];
      rx_next     = {mosi_s, rx_shift};
      rx_keep     = rx_next[7:1];
`else
      load_bit    = load_byte[7];
      tx_next     = {tx_shift[6:0], tx_shift[7]};
      tx_next_bit = tx_next[7];
      rx_next     = {rx_shift, mosi_s};
      rx_keep     = rx_next[6:0];
`endif
   end

   // Pin synchronisers and SCK edge detection. The edge pulses are registered. This keeps
   // pin-to-output latency at SYNC_STAGES+2 for every path.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= '1;
         sck_sync  <= '0;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         sck_rise  <= 1'b0;
         sck_fall  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sck_d     <= sck_s;
         sck_rise  <= sck_s & ~sck_d;
         sck_fall  <= ~sck_s & sck_d;
      end
   end

   // Control FSM with the tx/rx datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         busy        <= 1'b0;
         spi_miso    <= 1'b0;
         hold        <= 8'h00;
         hold_full   <= 1'b0;
         hold_loaded <= 1'b0;
         tx_shift    <= 8'h00;
         rx_shift    <= 7'h00;
         bit_cnt     <= 3'd0;
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         overrun <= 1'b0;

         if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end

         // A byte completing in this same cycle overrides this clear below.
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            StIdle: begin
               bit_cnt     <= 3'd0;
               hold_loaded <= 1'b0;
               if (!cs_s) begin
                  state <= StLoad;
                  busy  <= 1'b1;
               end
            end

            StLoad: begin
               if (cs_s) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else begin
                  tx_shift    <= load_byte;
                  spi_miso    <= load_bit;
                  hold_loaded <= hold_full;
                  bit_cnt     <= 3'd0;
                  state       <= StShift;
               end
            end

            StShift: begin
               if (cs_s) begin
                  // Abort: any partial byte is discarded.
                  state   <= StIdle;
                  busy    <= 1'b0;
                  bit_cnt <= 3'd0;
               end else if (sck_rise) begin
                  rx_shift <= rx_keep;
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd0 && hold_loaded) begin
                     hold_full   <= 1'b0;
                     hold_loaded <= 1'b0;
                  end
                  if (bit_cnt == 3'd7) begin
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end else if (sck_fall) begin
                  if (bit_cnt != 3'd0) begin
                     tx_shift <= tx_next;
                     spi_miso <= tx_next_bit;
                  end else begin
                     // Byte boundary: fetch the next byte. It is not consumed until its first
                     // SCK rise, so a trailing reload leaves the holding register full.
                     tx_shift    <= load_byte;
                     spi_miso    <= load_bit;
                     hold_loaded <= hold_full;
                  end
               end
            end

            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
module tb_spi_target;

   localparam int HALF = 6;  // SCK half period in clk cycles

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_cs;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       overrun;
   logic       busy;

   int n_total = 0;
   int n_pass  = 0;
   int ov_cnt  = 0;

   // Model: bytes accepted into the target wait here until a byte slot on the bus starts.
   logic [7:0] tx_q[$];
   // Model: bytes the target must deliver, in order.
   logic [7:0] rx_exp[$];

   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always #5 clk = ~clk;

   spi_target #(
      .FILL_BYTE  (8'hFF),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .spi_cs   (spi_cs),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .overrun  (overrun),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_miso"}, spi_miso, 0);
      chk({tag, "_tx_ready"}, tx_ready, 1);
      chk({tag, "_rx_valid"}, rx_valid, 0);
      chk({tag, "_rx_data"}, rx_data, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic load_tx(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 2000) begin
         clks(1);
         n++;
      end
      if (!tx_ready) chk("tx_ready_timeout", {31'b0, tx_ready}, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      clks(1);
      tx_valid = 1'b0;
      tx_q.push_back(b);
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      clks(6);
   endtask

   task automatic cs_high();
      clks(HALF);
      spi_cs = 1'b1;
      clks(10);
   endtask

   task automatic spi_bit(input logic b, output logic m);
      spi_mosi = b;
      clks(HALF);
      m = spi_miso;
      spi_sck = 1'b1;
      clks(HALF);
      spi_sck = 1'b0;
   endtask

   // One full byte as master. The expected MISO byte comes from the model queue.
   task automatic spi_byte(input logic [7:0] mo, input bit push_rx, input bit meas,
                           output logic [7:0] mi);
      logic [7:0] exp;
      int idx;
      int n;
      if (tx_q.size() > 0) exp = tx_q.pop_front();
      else exp = 8'hFF;
      mi = 8'h00;
      for (int i = 0; i < 8; i++) begin
`ifdef SPI_TARGET_LSB_FIRST_EN
         idx = i;
`else
         idx = 7 - i;
`endif
         spi_mosi = mo[idx];
         clks(HALF);
         mi[idx] = spi_miso;
         if (i == 7 && push_rx) rx_exp.push_back(mo);
         spi_sck = 1'b1;
         if (meas && i == 7) begin
            n = 0;
            while (!rx_valid && n < 10) begin
               clks(1);
               n++;
            end
            chk("rx_valid_latency", n, 4);
            clks((n < HALF) ? HALF - n : 1);
         end else begin
            clks(HALF);
         end
         spi_sck = 1'b0;
      end
      chk("miso_byte_model", mi, exp);
   endtask

   // Per-cycle receive-side checks against the model.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold) begin
            chk("rx_valid_held", rx_valid, 1);
            chk("rx_data_stable", rx_data, prev_data);
         end
         if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) chk("rx_unexpected_byte", rx_exp.size(), 1);
            else chk("rx_byte_order", rx_data, rx_exp.pop_front());
         end
         prev_hold <= rx_valid && !rx_ready;
         prev_data <= rx_data;
         if (overrun) ov_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] r;
      logic       m;
      logic [3:0] nib;

      rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
      clks(3);
      chk_reset_outputs("reset");
      rst = 1'b0;
      clks(2);

      // Single byte, rx held until rx_ready.
      load_tx(8'hA5);
      chk("tx_ready_after_load", tx_ready, 0);
      cs_low();
      chk("busy_in_transfer", busy, 1);
      spi_byte(8'h3C, 1, 1, r);
      chk("single_miso", r, 8'hA5);
      cs_high();
      chk("single_rx_valid", rx_valid, 1);
      chk("single_rx_data", rx_data, 8'h3C);
      chk("single_tx_ready", tx_ready, 1);
      chk("single_busy_idle", busy, 0);
      clks(5);
      chk("single_rx_still_valid", rx_valid, 1);
      rx_ready = 1'b1;
      clks(2);
      chk("single_rx_dropped", rx_valid, 0);
      chk("single_rx_drained", rx_exp.size(), 0);

      // Empty holding register: fill byte returned.
      cs_low();
      spi_byte(8'h01, 1, 0, r);
      chk("empty_miso0", r, 8'hFF);
      spi_byte(8'h02, 1, 0, r);
      chk("empty_miso1", r, 8'hFF);
      cs_high();
      chk("empty_rx_drained", rx_exp.size(), 0);

      // Overrun.
      rx_ready = 1'b0;
      ov_cnt = 0;
      cs_low();
      spi_byte(8'h11, 1, 0, r);
      spi_byte(8'h22, 0, 0, r);
      cs_high();
      chk("ovr_pulses", ov_cnt, 1);
      chk("ovr_rx_valid", rx_valid, 1);
      chk("ovr_rx_data", rx_data, 8'h11);
      rx_ready = 1'b1;
      clks(3);
      chk("ovr_rx_drained", rx_exp.size(), 0);

      // Abort after 4 SCK.
      load_tx(8'h5A);
      void'(tx_q.pop_front());
      cs_low();
      nib = 4'h0;
      for (int i = 0; i < 4; i++) begin
         spi_bit(1'b1, m);
         nib = {nib[2:0], m};
      end
      cs_high();
      chk("abort_miso_bits", nib, 4'h5);
      chk("abort_rx_valid", rx_valid, 0);
      chk("abort_tx_ready", tx_ready, 1);
      cs_low();
      spi_byte(8'h77, 1, 0, r);
      chk("abort_next_miso", r, 8'hFF);
      cs_high();
      chk("abort_rx_drained", rx_exp.size(), 0);

      // Back-to-back with refill.
      load_tx(8'hF0);
      cs_low();
      fork
         begin
            for (int k = 1; k < 5; k++) load_tx(8'hF0 + k[7:0]);
         end
         begin
            for (int k = 0; k < 4; k++) begin
               spi_byte(k[7:0], 1, 0, r);
               chk("b2b_miso", r, 8'hF0 + k);
            end
         end
      join
      cs_high();
      chk("b2b_tx_ready_trailing", tx_ready, 0);
      chk("b2b_rx_drained", rx_exp.size(), 0);
      chk("b2b_model_left", tx_q.size(), 1);
      chk("b2b_last_rx", rx_data, 8'h03);

      // Reset mid-transfer.
      cs_low();
      for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
      rst = 1'b1;
      clks(2);
      chk_reset_outputs("midrst");
      spi_cs = 1'b1;
      spi_sck = 1'b0;
      clks(1);
      rst = 1'b0;
      tx_q.delete();
      rx_exp.delete();
      clks(6);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_tx_ready", tx_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (responder) for the chip's SPI bus: the far end of the SoC's SPI master (cs, sck, mosi, miso), used as an on-die loopback/peripheral endpoint and as the bench-side responder. It oversamples the SPI pins in the system clock domain, deserialises MOSI into bytes with a valid/ready output handshake, and serialises bytes from a one-entry transmit holding register onto MISO. It requires a system clock of at least 4× SCK and contains a three-state control FSM.

## Interface
- FILL_BYTE, 8'hFF, byte shifted out on MISO when the transmit holding register is empty at a byte start
- SYNC_STAGES, 2, synchroniser depth on spi_cs/spi_sck/spi_mosi (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- spi_cs  in  1  chip select from master, active low
- spi_sck  in  1  serial clock, idles low (mode 0)
- spi_mosi  in  1  master-out data
- spi_miso  out  1  target-out data, registered
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; transfer on tx_valid&&tx_ready
- rx_data  out  8  received byte, stable while rx_valid
- rx_valid  out  1  rx_data valid; held until rx_ready
- rx_ready  in  1  consumer accepts rx_data
- overrun  out  1  one-cycle pulse: received byte dropped
- busy  out  1  high while FSM is not IDLE

## Operation
- Synchronised cs_s/sck_s/mosi_s after SYNC_STAGES flops; one extra flop on sck_s gives sck_rise/sck_fall pulses.
- FSM IDLE: cs_s=1. cs_s=0 → LOAD. LOAD (one cycle): tx shift register ← holding (if full) else FILL_BYTE; bit counter ← 0; → SHIFT. SHIFT: cs_s=1 → IDLE (from any state).
- spi_miso registered from tx shift register MSB (bit 7).
- sck_rise in SHIFT: rx shift ← {rx_shift[6:0], mosi_s}; counter +1 mod 8. Counter 7→0 completes a byte.
- Completed byte: if rx_valid=0, or rx_valid&&rx_ready this cycle → rx_data ← byte, rx_valid←1. Otherwise byte dropped, rx_data unchanged, overrun pulses.
- sck_fall in SHIFT: counter≠0 → shift tx register left; counter=0 (byte boundary) → reload from holding/FILL_BYTE as in LOAD.
- Holding register consumed (tx_ready→1) only on the first sck_rise of the byte it was loaded into; a trailing reload after the final byte does not consume it.
- tx_ready = !hold_full; accepting tx_valid sets hold_full.
- CS rise mid-byte: abort, counter←0, partial rx bits discarded (no rx_valid); holding-register consumption per rule above.
- Reset: FSM IDLE, spi_miso=0, tx_ready=1, hold empty, rx_valid=0, rx_data=0, overrun=0, busy=0, counter=0, sync flops 1 for cs, 0 for sck/mosi.

## Timing
- spi_cs pin fall → spi_miso valid: SYNC_STAGES+2 clk cycles. Master must give ≥SYNC_STAGES+3 clk before first SCK rise.
- SCK high and low phases each ≥2 clk cycles.
- 8th SCK pin rise → rx_valid high: SYNC_STAGES+2 clk cycles.
- SCK pin fall → spi_miso update: SYNC_STAGES+2 clk cycles (well inside the half period).
- rx_valid drops the cycle after rx_valid&&rx_ready; tx_ready drops the cycle after acceptance.
- rst dominates all inputs in the same cycle.

## Configuration
- SPI_TARGET_LSB_FIRST_EN defined: both directions LSB first (rx shift right into bit 7, spi_miso from bit 0, tx shift right).
- Undefined (default): MSB first as described above.

## Test plan
- Reset: assert rst 2 cycles mid-transfer → all outputs at reset values, busy=0, tx_ready=1.
- Single byte: load tx 8'hA5, master sends 8'h3C → master reads 8'hA5, rx_data=8'h3C with rx_valid held until rx_ready.
- Empty holding: no tx load, 2-byte transfer sending 8'h01,8'h02 → master reads 8'hFF,8'hFF; both bytes received in order with rx_ready=1.
- Overrun: rx_ready=0, send 8'h11 then 8'h22 → rx_data stays 8'h11, one overrun pulse.
- Abort: load 8'h5A, CS high after 4 SCK → no rx_valid, tx_ready=1; next transfer returns 8'hFF.
- Back-to-back: refill tx after each tx_ready, send 4 bytes 8'h00..8'h03 returning 8'hF0..8'hF3 → exact echo both directions; trailing reload leaves a 5th loaded byte unconsumed (tx_ready=0).
